// File: rtl/ysyx_22041461_pc_gen.sv
// Fetch-side PC generator: issues one IF request at a time and buffers
// the returned instruction for ID. Back-end redirects squash stale fetches.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   fetch_valid/pc      request pulse and address to IF
//   fetch_done/inst     IF completion and returned instruction
//   id_valid/ready      one-entry output buffer handshake to ID
//   id_pc/inst          contents of the output buffer
//   redirect_valid/pc   restart fetch at a new target (bits [1:0] dropped)
module ysyx_22041461_pc_gen #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        fetch_valid,
    output logic [63:0] fetch_pc,
    input  logic        fetch_done,
    input  logic [31:0] fetch_inst,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [63:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    localparam logic [1:0] S_BOOT = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]  r_state;
    logic [63:0] r_pc;
    logic        r_kill;
    logic        r_id_valid;
    logic [63:0] r_id_pc;
    logic [31:0] r_id_inst;

    logic [63:0] w_redir_pc;
    logic [63:0] w_pc_inc;

    assign w_redir_pc = redirect_pc & ~64'h3;
    assign w_pc_inc   = r_pc + 64'd4;

    assign fetch_valid = (r_state == S_REQ);
    assign fetch_pc    = r_pc;
    assign id_valid    = r_id_valid;
    assign id_pc       = r_id_pc;
    assign id_inst     = r_id_inst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_BOOT;
            r_pc       <= RESET_PC;
            r_kill     <= 1'b0;
            r_id_valid <= 1'b0;
            r_id_pc    <= 64'd0;
            r_id_inst  <= 32'd0;
        end else if (redirect_valid) begin
            r_pc       <= w_redir_pc;
            r_id_valid <= 1'b0;
            unique case (r_state)
                // A request is outstanding: its response must be dropped.
                S_REQ: begin
                    r_kill  <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fetch_done) begin
                        r_kill  <= 1'b0;
                        r_state <= S_REQ;
                    end else begin
                        r_kill  <= 1'b1;
                    end
                end
                S_BOOT, S_HOLD: begin
                    r_state <= S_REQ;
                end
            endcase
        end else begin
            unique case (r_state)
                S_BOOT: begin
                    r_state <= S_REQ;
                end
                S_REQ: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (fetch_done) begin
                        if (r_kill) begin
                            r_kill  <= 1'b0;
                            r_state <= S_REQ;
                        end else begin
                            r_id_pc    <= r_pc;
                            r_id_inst  <= fetch_inst;
                            r_id_valid <= 1'b1;
                            r_pc       <= w_pc_inc;
                            r_state    <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (r_id_valid && id_ready) begin
                        r_id_valid <= 1'b0;
                        r_state    <= S_REQ;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041461_pc_gen.sv
// Bench for ysyx_22041461_pc_gen: scripted IF responses, a scoreboard of
// instructions that must reach ID, and direct checks of fetch behaviour.
module tb_ysyx_22041461_pc_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_done = 1'b0;
    logic [31:0] fetch_inst = 32'd0;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        sel = 1'b0;

    logic        fv0, fv1, iv0, iv1;
    logic [63:0] fp0, fp1, ip0, ip1;
    logic [31:0] ii0, ii1;

    logic        w_fv, w_idv;
    logic [63:0] w_fpc, w_idpc;
    logic [31:0] w_idinst;

    assign w_fv     = sel ? fv1 : fv0;
    assign w_fpc    = sel ? fp1 : fp0;
    assign w_idv    = sel ? iv1 : iv0;
    assign w_idpc   = sel ? ip1 : ip0;
    assign w_idinst = sel ? ii1 : ii0;

    ysyx_22041461_pc_gen u_dut0 (
        .clk(clk), .rst(rst),
        .fetch_valid(fv0), .fetch_pc(fp0),
        .fetch_done(fetch_done), .fetch_inst(fetch_inst),
        .id_valid(iv0), .id_ready(id_ready),
        .id_pc(ip0), .id_inst(ii0),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    ysyx_22041461_pc_gen #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) u_dut1 (
        .clk(clk), .rst(rst),
        .fetch_valid(fv1), .fetch_pc(fp1),
        .fetch_done(fetch_done), .fetch_inst(fetch_inst),
        .id_valid(iv1), .id_ready(id_ready),
        .id_pc(ip1), .id_inst(ii1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Must be called in a REQ cycle; answers after lat cycles.
    task automatic do_fetch(input int lat, input logic [31:0] inst,
                            input bit push);
        logic [63:0] pc;
        chk("req_valid", {63'd0, w_fv}, 64'd1);
        pc = w_fpc;
        for (int i = 0; i < lat; i++) begin
            tick();
            chk("wait_fv", {63'd0, w_fv}, 64'd0);
            chk("pc_stable", w_fpc, pc);
        end
        fetch_done = 1'b1;
        fetch_inst = inst;
        tick();
        fetch_done = 1'b0;
        if (push) sb.push_back('{pc: pc, inst: inst});
    endtask

    task automatic accept();
        exp_t e;
        int n = 0;
        while (!w_idv && n < 10) begin
            tick();
            n++;
        end
        chk("id_valid_seen", {63'd0, w_idv}, 64'd1);
        if (sb.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            chk("id_pc", w_idpc, e.pc);
            chk("id_inst", {32'd0, w_idinst}, {32'd0, e.inst});
        end
        id_ready = 1'b1;
        tick();
        id_ready = 1'b0;
    endtask

    initial begin
        // reset state
        tick();
        chk("rst_fv", {63'd0, w_fv}, 64'd0);
        chk("rst_idv", {63'd0, w_idv}, 64'd0);
        chk("rst_idpc", w_idpc, 64'd0);
        chk("rst_idinst", {32'd0, w_idinst}, 64'd0);
        chk("rst_fpc", w_fpc, 64'h8000_0000);
        rst = 1'b1;
        tick();

        // 1: basic fetch, 3-cycle IF
        do_fetch(3, 32'h0000_0013, 1'b1);
        chk("t1_idv", {63'd0, w_idv}, 64'd1);
        accept();
        chk("t1_next_fv", {63'd0, w_fv}, 64'd1);
        chk("t1_next_pc", w_fpc, 64'h8000_0004);

        // 2: ID stalls in HOLD
        do_fetch(1, 32'h1111_1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_idv", {63'd0, w_idv}, 64'd1);
            chk("t2_fv", {63'd0, w_fv}, 64'd0);
            chk("t2_idpc", w_idpc, 64'h8000_0004);
            chk("t2_idinst", {32'd0, w_idinst}, 64'h1111_1111);
        end
        accept();
        chk("t2_fv_after", {63'd0, w_fv}, 64'd1);
        chk("t2_pc_after", w_fpc, 64'h8000_0008);

        // 3: redirect while request outstanding
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_1000;
        tick();
        redirect_valid = 1'b0;
        tick();
        fetch_done = 1'b1;
        fetch_inst = 32'hDEAD_BEEF;
        tick();
        fetch_done = 1'b0;
        chk("t3_idv", {63'd0, w_idv}, 64'd0);
        chk("t3_fv", {63'd0, w_fv}, 64'd1);
        chk("t3_pc", w_fpc, 64'h8000_1000);
        do_fetch(2, 32'h2222_2222, 1'b1);
        accept();

        // 4: redirect coincident with fetch_done
        tick();
        fetch_done = 1'b1;
        fetch_inst = 32'hBAD0_BAD0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_2002;
        tick();
        fetch_done = 1'b0;
        redirect_valid = 1'b0;
        chk("t4_fv", {63'd0, w_fv}, 64'd1);
        chk("t4_pc", w_fpc, 64'h8000_2000);
        chk("t4_idv", {63'd0, w_idv}, 64'd0);
        do_fetch(1, 32'h3333_3333, 1'b1);
        accept();

        // 5: redirect in HOLD, without and with id_ready
        do_fetch(1, 32'h4444_4444, 1'b0);
        chk("t5_hold", {63'd0, w_idv}, 64'd1);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_3000;
        tick();
        redirect_valid = 1'b0;
        chk("t5a_idv", {63'd0, w_idv}, 64'd0);
        chk("t5a_fv", {63'd0, w_fv}, 64'd1);
        chk("t5a_pc", w_fpc, 64'h8000_3000);
        do_fetch(1, 32'h5555_5555, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h8000_4000;
        id_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        chk("t5b_idv", {63'd0, w_idv}, 64'd0);
        chk("t5b_fv", {63'd0, w_fv}, 64'd1);
        chk("t5b_pc", w_fpc, 64'h8000_4000);
        do_fetch(1, 32'h6666_6666, 1'b1);
        accept();

        // 6: wrap-around reset PC and async reset mid-WAIT
        sel = 1'b1;
        rst = 1'b0;
        #1;
        chk("t6_rst_fv", {63'd0, w_fv}, 64'd0);
        chk("t6_rst_pc", w_fpc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_pc0", w_fpc, 64'hFFFF_FFFF_FFFF_FFFC);
        do_fetch(1, 32'h7777_7777, 1'b1);
        accept();
        chk("t6_fv1", {63'd0, w_fv}, 64'd1);
        chk("t6_wrap", w_fpc, 64'd0);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_fv", {63'd0, w_fv}, 64'd0);
        chk("t6_async_idv", {63'd0, w_idv}, 64'd0);
        chk("t6_async_idpc", w_idpc, 64'd0);
        chk("t6_async_idinst", {32'd0, w_idinst}, 64'd0);
        chk("t6_async_pc", w_fpc, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        rst = 1'b1;
        tick();
        chk("t6_restart_fv", {63'd0, w_fv}, 64'd1);
        chk("t6_restart_pc", w_fpc, 64'hFFFF_FFFF_FFFF_FFFC);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
